// File: rtl/spi_dac_wave_nch.sv
// rtl/spi_dac_wave_nch.sv - N-channel SPI sine DAC driver with per-channel phase offset
module spi_dac_wave_nch #(
   parameter int N_CH    = 2,
   parameter int DATA_W  = 12,
   parameter int FRAME_W = 16,
   parameter int LUT_AW  = 6,
   parameter int PH_OFF  = 16,
   parameter int DIV     = 4,
   parameter int CS_GAP  = 2,
   parameter logic [(2**LUT_AW)*DATA_W-1:0] LUT_INIT = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic              stop_i,
   input  logic [LUT_AW-1:0] step_i,
   output logic              mosi_o,
   output logic              sck_o,
   output logic              cs_o,
   output logic              busy_o,
   output logic              end_o
);

   localparam int N_LUT = 2**LUT_AW;
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   // All-zero LUT_INIT selects a built-in offset-binary sine (Bhaskara approximation,
   // exact at the zero crossings and peaks).
   function automatic logic [N_LUT*DATA_W-1:0] sine_image();
      logic [N_LUT*DATA_W-1:0] img;
      longint half, mid, j, t, v;
      img  = '0;
      half = longint'(N_LUT / 2);
      mid  = longint'(1) << (DATA_W - 1);
      for (int k = 0; k < N_LUT; k++) begin
         j = longint'(k) % half;
         t = j * (half - j);
         v = ((mid - 1) * 16 * t) / (5 * half * half - 4 * t);
         img[k*DATA_W +: DATA_W] = (longint'(k) < half) ? DATA_W'(mid + v) : DATA_W'(mid - v);
      end
      return img;
   endfunction

   localparam logic [N_LUT*DATA_W-1:0] LUT_IMG = (LUT_INIT == '0) ? sine_image() : LUT_INIT;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t              state;
   logic                mode_l;
   logic                stop_lat;
   logic [LUT_AW-1:0]   step_l;
   logic [LUT_AW-1:0]   idx;
   logic [CH_W-1:0]     ch;
   logic [FRAME_W-1:0]  shreg;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [GAP_W-1:0]    gap_cnt;

   logic [LUT_AW-1:0]   addr;
   logic [DATA_W-1:0]   sample;
   logic [FRAME_W-1:0]  frame;
   logic [LUT_AW:0]     idx_sum;
   logic                last_ch;
   logic                stop_seen;

   always_comb begin
      addr      = idx + LUT_AW'(ch) * LUT_AW'(PH_OFF);
      sample    = LUT_IMG[int'(addr)*DATA_W +: DATA_W];
      frame     = (FRAME_W'(ch) << DATA_W) | FRAME_W'(sample);
      idx_sum   = {1'b0, idx} + {1'b0, step_l};
      last_ch   = (ch == CH_W'(N_CH - 1));
      stop_seen = stop_lat | (mode_l & stop_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         mode_l   <= 1'b0;
         stop_lat <= 1'b0;
         step_l   <= LUT_AW'(1);
         idx      <= '0;
         ch       <= '0;
         shreg    <= '0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         mosi_o   <= 1'b0;
         sck_o    <= 1'b0;
         cs_o     <= 1'b1;
         busy_o   <= 1'b0;
         end_o    <= 1'b0;
      end else begin
         end_o <= 1'b0;
         if (state != S_IDLE && mode_l && stop_i)
            stop_lat <= 1'b1;

         case (state)
            S_IDLE: begin
               if (start_i) begin
                  mode_l   <= mode_i;
                  step_l   <= (step_i == '0) ? LUT_AW'(1) : step_i;
                  idx      <= '0;
                  ch       <= '0;
                  stop_lat <= 1'b0;
                  busy_o   <= 1'b1;
                  state    <= S_LOAD;
               end
            end

            S_LOAD: begin
               shreg   <= frame;
               mosi_o  <= frame[FRAME_W-1];
               cs_o    <= 1'b0;
               sck_o   <= 1'b0;
               div_cnt <= '0;
               bit_cnt <= '0;
               state   <= S_SHIFT;
            end

            S_SHIFT: begin
               if (div_cnt == DIV_W'(DIV - 1)) begin
                  div_cnt <= '0;
                  if (!sck_o) begin
                     sck_o <= 1'b1;
                  end else if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                     sck_o   <= 1'b0;
                     cs_o    <= 1'b1;
                     mosi_o  <= 1'b0;
                     gap_cnt <= '0;
                     state   <= S_GAP;
                  end else begin
                     // Falling edge: present the next bit for the DAC's rising-edge sample.
                     sck_o   <= 1'b0;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     shreg   <= shreg << 1;
                     mosi_o  <= shreg[FRAME_W-2];
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            S_GAP: begin
               if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                  if (!last_ch) begin
                     ch    <= ch + CH_W'(1);
                     state <= S_LOAD;
                  end else begin
                     ch  <= '0;
                     idx <= idx_sum[LUT_AW-1:0];
                     if (idx_sum[LUT_AW] || stop_seen)
                        end_o <= 1'b1;
                     if ((!mode_l && idx_sum[LUT_AW]) || stop_seen) begin
                        busy_o   <= 1'b0;
                        stop_lat <= 1'b0;
                        state    <= S_IDLE;
                     end else begin
                        state <= S_LOAD;
                     end
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_dac_wave_nch.sv
// tb/tb_spi_dac_wave_nch.sv - timeline model, SPI frame monitor and directed scenarios
module tb_spi_dac_wave_nch;

   localparam int N_CH = 2, DATA_W = 12, FRAME_W = 16, LUT_AW = 4, PH_OFF = 4;
   localparam int DIV = 2, CS_GAP = 2, N_LUT = 16;
   localparam int SHIFT_CYC = 2 * DIV * FRAME_W;
   localparam int SLOT = 1 + SHIFT_CYC + CS_GAP;
   localparam int SET  = N_CH * SLOT;
   localparam logic [N_LUT*DATA_W-1:0] LUT_PK = {
      12'h4EE, 12'h24D, 12'h0AC, 12'h00B, 12'h09A, 12'h269, 12'h4F8, 12'h817,
      12'hB06, 12'hDB5, 12'hF54, 12'hFFF, 12'hF63, 12'hDA2, 12'hB11, 12'h800};

   logic       clk = 1'b0, rst = 1'b1;
   logic       start_i = 1'b0, mode_i = 1'b0, stop_i = 1'b0;
   logic [3:0] step_i = 4'd0;
   logic       mosi_o, sck_o, cs_o, busy_o, end_o;

   spi_dac_wave_nch #(
      .N_CH(N_CH), .DATA_W(DATA_W), .FRAME_W(FRAME_W), .LUT_AW(LUT_AW),
      .PH_OFF(PH_OFF), .DIV(DIV), .CS_GAP(CS_GAP), .LUT_INIT(LUT_PK)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_i), .mode_i(mode_i), .stop_i(stop_i),
      .step_i(step_i), .mosi_o(mosi_o), .sck_o(sck_o), .cs_o(cs_o), .busy_o(busy_o),
      .end_o(end_o)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit wraps(input int m, input int st);
      return ((m + 1) * st) / N_LUT != (m * st) / N_LUT;
   endfunction

   // Frame for slot s of a run: slot -> (index number, channel) -> ROM address.
   function automatic logic [15:0] frame_of(input int s, input int st);
      int c, m, a;
      c = s % N_CH;
      m = s / N_CH;
      a = (m * st + c * PH_OFF) % N_LUT;
      return {4'(c), LUT_PK[a*DATA_W +: DATA_W]};
   endfunction

   // Model: t counts cycles since the first LOAD of the run.
   bit running = 1'b0, md = 1'b0, end_exp = 1'b0;
   int t = 0, stp = 1, stop_m = -1;

   always @(posedge clk or posedge rst) begin : model
      int m;
      if (rst) begin
         running = 1'b0; t = 0; end_exp = 1'b0; stop_m = -1;
      end else begin
         end_exp = 1'b0;
         if (running) begin
            if (md && stop_i && stop_m < 0) stop_m = t / SET;
            t++;
            if (t % SET == 0) begin
               m = t / SET - 1;
               end_exp = wraps(m, stp) || (stop_m >= 0 && stop_m <= m);
               if ((!md && wraps(m, stp)) || (stop_m >= 0 && stop_m <= m)) running = 1'b0;
            end
         end else if (start_i) begin
            running = 1'b1; t = 0; md = mode_i; stop_m = -1;
            stp = (step_i == 4'd0) ? 1 : int'(step_i);
         end
      end
   end

   always @(negedge clk) begin : compare
      int p, q;
      logic [15:0] fr;
      if (!rst) begin
         check("busy", 32'(busy_o), 32'(running));
         check("end", 32'(end_o), 32'(end_exp));
         p = t % SLOT;
         if (running && p >= 1 && p <= SHIFT_CYC) begin
            q  = p - 1;
            fr = frame_of(t / SLOT, stp);
            check("cs_low", 32'(cs_o), 0);
            check("sck", 32'(sck_o), 32'((q % (2 * DIV)) >= DIV));
            check("mosi", 32'(mosi_o), 32'(fr[15 - q / (2 * DIV)]));
         end else begin
            check("cs_high", 32'(cs_o), 1);
            check("sck_idle", 32'(sck_o), 0);
         end
      end
   end

   logic        prev_cs = 1'b1, prev_sck = 1'b0;
   logic [15:0] sh = '0;
   int          nb = 0, lowc = 0, n_end = 0, n_fall = 0;
   logic [15:0] cap_q[$];

   always @(negedge clk) begin : monitor
      if (rst) begin
         prev_cs = 1'b1; prev_sck = 1'b0;
      end else begin
         if (end_o) n_end++;
         if (!cs_o) begin
            if (prev_cs) begin n_fall++; sh = '0; nb = 0; lowc = 0; end
            lowc++;
            if (sck_o && !prev_sck) begin sh = {sh[14:0], mosi_o}; nb++; end
         end else if (!prev_cs) begin
            check("frame_bits", 32'(nb), 16);
            check("cs_low_cycles", 32'(lowc), 64);
            check("frame", 32'(sh), 32'(frame_of(t / SLOT, stp)));
            cap_q.push_back(sh);
         end
         prev_cs = cs_o; prev_sck = sck_o;
      end
   end

   task automatic start_run(input logic md_, input logic [3:0] st);
      @(negedge clk);
      mode_i = md_; step_i = st; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy_o && n < budget) begin @(negedge clk); n++; end
      check({name, "_timeout"}, 32'(busy_o), 0);
   endtask

   task automatic wait_t(input string name, input int target, input int budget);
      int n;
      n = 0;
      while (!(running && t == target) && n < budget) begin @(negedge clk); n++; end
      check({name, "_reach"}, 32'(t), 32'(target));
   endtask

   int b, e, f, n;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(cs_o), 1);
      check("rst_sck", 32'(sck_o), 0);
      check("rst_mosi", 32'(mosi_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_end", 32'(end_o), 0);
      rst = 1'b0;

      // T1: mode 0, step 1
      b = cap_q.size(); e = n_end;
      start_run(1'b0, 4'd1);
      wait_idle("t1", 17 * SET);
      repeat (5) @(negedge clk);
      check("t1_frame0", 32'(cap_q[b]), 32'h0800);
      check("t1_frame1", 32'(cap_q[b+1]), 32'h1FFF);
      check("t1_frames", 32'(cap_q.size() - b), 32);
      check("t1_ends", 32'(n_end - e), 1);

      // T2: mode 0, step 4
      b = cap_q.size(); e = n_end; f = n_fall;
      start_run(1'b0, 4'd4);
      wait_idle("t2", 5 * SET);
      repeat (20) @(negedge clk);
      check("t2_frames", 32'(cap_q.size() - b), 8);
      check("t2_cs_falls", 32'(n_fall - f), 8);
      check("t2_ends", 32'(n_end - e), 1);
      check("t2_frame2", 32'(cap_q[b+2]), 32'h0FFF);
      check("t2_frame3", 32'(cap_q[b+3]), 32'h1817);

      // T3: continuous, stop during ch0 frame of idx 5
      b = cap_q.size(); e = n_end; f = n_fall;
      start_run(1'b1, 4'd1);
      wait_t("t3", 5 * SET + 10, 7 * SET);
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      wait_idle("t3", 2 * SET);
      repeat (300) @(negedge clk);
      check("t3_frames", 32'(cap_q.size() - b), 12);
      check("t3_cs_falls", 32'(n_fall - f), 12);
      check("t3_last", 32'(cap_q[b+11]), 32'h14F8);
      check("t3_ends", 32'(n_end - e), 1);

      // T4: reset at bit 7 of the first frame, then replay
      start_run(1'b0, 4'd1);
      wait_t("t4", 30, 100);
      check("t4_mid_frame", 32'(cs_o), 0);
      #2 rst = 1'b1;
      #1;
      check("t4_cs", 32'(cs_o), 1);
      check("t4_sck", 32'(sck_o), 0);
      check("t4_mosi", 32'(mosi_o), 0);
      check("t4_busy", 32'(busy_o), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      b = cap_q.size();
      start_run(1'b0, 4'd8);
      wait_idle("t4", 3 * SET);
      repeat (5) @(negedge clk);
      check("t4_f0", 32'(cap_q[b]), 32'h0800);
      check("t4_f1", 32'(cap_q[b+1]), 32'h1FFF);
      check("t4_f2", 32'(cap_q[b+2]), 32'h0817);
      check("t4_f3", 32'(cap_q[b+3]), 32'h100B);

      // T5: start held high, re-pulsed while busy
      b = cap_q.size();
      @(negedge clk);
      mode_i = 1'b0; step_i = 4'd8; start_i = 1'b1;
      n = 0;
      while (!busy_o && n < 10) begin @(negedge clk); n++; end
      repeat (50) @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      start_i = 1'b1;
      wait_idle("t5a", 3 * SET);
      n = 0;
      while (!busy_o && n < 10) begin n++; @(negedge clk); end
      check("t5_idle_gap", 32'(n), 1);
      start_i = 1'b0;
      wait_idle("t5b", 3 * SET);
      repeat (5) @(negedge clk);
      check("t5_frames", 32'(cap_q.size() - b), 8);

      // T6: step 0 acts as step 1
      b = cap_q.size(); e = n_end;
      start_run(1'b0, 4'd0);
      wait_idle("t6", 17 * SET);
      repeat (5) @(negedge clk);
      check("t6_frames", 32'(cap_q.size() - b), 32);
      check("t6_ends", 32'(n_end - e), 1);
      check("t6_frame2", 32'(cap_q[b+2]), 32'h0B11);
      check("t6_last", 32'(cap_q[b+31]), 32'h1F63);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
